regs_port_arbiter: RTL and testbench

//  Shares the register-file memory (separate write and read ports, 1-cycle read latency) between two requesters.
//  AXI side: the slave register front-end, whose dev_ready is driven from a_*_ready.
//  HW side: SATA host/DMA engine status/command updates.

---
 rtl/regs_port_arbiter_pkg.sv | 14 +
 rtl/regs_port_arbiter_if.sv | 58 +++++
 rtl/regs_port_arbiter_grant.sv | 41 ++++
 rtl/regs_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_regs_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regs_port_arbiter_pkg.sv
// Shared constants for the register-file port arbiter: read-return owner codes and starve counter width.
// No logic, no latency.
// No backpressure.
package regs_arb_pkg;

    localparam int STARVE_W = 4;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_AXI  = 2'd1;
    localparam owner_t OWN_HW   = 2'd2;

endpackage

// File: rtl/regs_port_arbiter_if.sv
// Bundle of AXI-side, HW-side and memory-side signals around the register-file arbiter.
// No logic, no latency.
// Backpressure carried by the *_wready/*_rready grant signals.
interface regs_port_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32
);
    localparam int STB_BITS = DATA_BITS / 8;

    logic                 a_wen;
    logic [ADDR_BITS-1:0] a_waddr;
    logic [DATA_BITS-1:0] a_wdata;
    logic [STB_BITS-1:0]  a_wstb;
    logic                 a_wready;
    logic                 a_ren;
    logic [ADDR_BITS-1:0] a_raddr;
    logic                 a_rready;
    logic                 a_rvalid;
    logic [DATA_BITS-1:0] a_rdata;

    logic                 h_wen;
    logic [ADDR_BITS-1:0] h_waddr;
    logic [DATA_BITS-1:0] h_wdata;
    logic [STB_BITS-1:0]  h_wstb;
    logic                 h_wready;
    logic                 h_ren;
    logic [ADDR_BITS-1:0] h_raddr;
    logic                 h_rready;
    logic                 h_rvalid;
    logic [DATA_BITS-1:0] h_rdata;

    logic                 mem_wen;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [STB_BITS-1:0]  mem_wstb;
    logic                 mem_ren;
    logic [ADDR_BITS-1:0] mem_raddr;
    logic [DATA_BITS-1:0] mem_rdata;

    modport slave (
        input  a_wen, a_waddr, a_wdata, a_wstb, a_ren, a_raddr,
        output a_wready, a_rready, a_rvalid, a_rdata,
        input  h_wen, h_waddr, h_wdata, h_wstb, h_ren, h_raddr,
        output h_wready, h_rready, h_rvalid, h_rdata,
        output mem_wen, mem_waddr, mem_wdata, mem_wstb, mem_ren, mem_raddr,
        input  mem_rdata
    );

    modport master (
        output a_wen, a_waddr, a_wdata, a_wstb, a_ren, a_raddr,
        input  a_wready, a_rready, a_rvalid, a_rdata,
        output h_wen, h_waddr, h_wdata, h_wstb, h_ren, h_raddr,
        input  h_wready, h_rready, h_rvalid, h_rdata,
        input  mem_wen, mem_waddr, mem_wdata, mem_wstb, mem_ren, mem_raddr,
        output mem_rdata
    );

endinterface

// File: rtl/regs_port_arbiter_grant.sv
// Two-requester grant: HW wins unless AXI has been denied STARVE_LIMIT cycles in a row.
// Latency: combinational grant; starve counter updates each cycle.
// Backpressure: a denied requester simply keeps its request level asserted.
module regs_grant
    import regs_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic aclk,
    input  logic arst,
    input  logic a_req_i,
    input  logic h_req_i,
    output logic a_gnt_o,
    output logic h_gnt_o
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    assign a_gnt_o = a_req_i & (~h_req_i | (starve_q == LIMIT_C));
    assign h_gnt_o = h_req_i & ~a_gnt_o;

    // Counter only survives while AXI keeps asking and keeps losing.
    always_comb begin
        starve_d = '0;
        if (a_req_i && !a_gnt_o) begin
            starve_d = (starve_q == '1) ? starve_q : starve_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/regs_port_arbiter.sv
// Shares a 1-cycle-read register-file memory between AXI and HW requesters (REGS_ARB_BYPASS_EN: same-address write-to-read merge).
// Latency: grants combinational, read data returns the cycle after the read grant.
// Backpressure: *_wready/*_rready low while the other side owns that port.
module regs_port_arbiter
    import regs_arb_pkg::*;
#(
    parameter int ADDR_BITS    = 16,
    parameter int DATA_BITS    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic aclk,
    input  logic arst,
    regs_port_arbiter_if.slave bus
);

    localparam int STB_BITS = DATA_BITS / 8;

    logic a_wgnt, h_wgnt, a_rgnt, h_rgnt;

    regs_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_wgnt (
        .aclk    (aclk),
        .arst    (arst),
        .a_req_i (bus.a_wen),
        .h_req_i (bus.h_wen),
        .a_gnt_o (a_wgnt),
        .h_gnt_o (h_wgnt)
    );

    regs_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_rgnt (
        .aclk    (aclk),
        .arst    (arst),
        .a_req_i (bus.a_ren),
        .h_req_i (bus.h_ren),
        .a_gnt_o (a_rgnt),
        .h_gnt_o (h_rgnt)
    );

    assign bus.a_wready = a_wgnt;
    assign bus.h_wready = h_wgnt;
    assign bus.a_rready = a_rgnt;
    assign bus.h_rready = h_rgnt;

    logic [ADDR_BITS-1:0] mem_waddr, mem_raddr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [STB_BITS-1:0]  mem_wstb;

    always_comb begin
        mem_waddr = '0;
        mem_wdata = '0;
        mem_wstb  = '0;
        if (h_wgnt) begin
            mem_waddr = bus.h_waddr;
            mem_wdata = bus.h_wdata;
            mem_wstb  = bus.h_wstb;
        end else if (a_wgnt) begin
            mem_waddr = bus.a_waddr;
            mem_wdata = bus.a_wdata;
            mem_wstb  = bus.a_wstb;
        end
    end

    always_comb begin
        mem_raddr = '0;
        if (h_rgnt) begin
            mem_raddr = bus.h_raddr;
        end else if (a_rgnt) begin
            mem_raddr = bus.a_raddr;
        end
    end

    assign bus.mem_wen   = a_wgnt | h_wgnt;
    assign bus.mem_waddr = mem_waddr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_wstb  = mem_wstb;
    assign bus.mem_ren   = a_rgnt | h_rgnt;
    assign bus.mem_raddr = mem_raddr;

    owner_t owner_q, owner_d;

    always_comb begin
        owner_d = OWN_NONE;
        if (a_rgnt) begin
            owner_d = OWN_AXI;
        end else if (h_rgnt) begin
            owner_d = OWN_HW;
        end
    end

    logic [DATA_BITS-1:0] ret_data;

`ifdef REGS_ARB_BYPASS_EN
    logic                 byp_hit_q;
    logic [DATA_BITS-1:0] byp_data_q;
    logic [STB_BITS-1:0]  byp_stb_q;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
            byp_stb_q  <= '0;
        end else begin
            byp_hit_q  <= bus.mem_wen & bus.mem_ren & (mem_waddr == mem_raddr);
            byp_data_q <= mem_wdata;
            byp_stb_q  <= mem_wstb;
        end
    end

    // Memory is read-first, so the freshly written bytes are patched in here.
    always_comb begin
        ret_data = bus.mem_rdata;
        if (byp_hit_q) begin
            for (int b = 0; b < STB_BITS; b++) begin
                if (byp_stb_q[b]) begin
                    ret_data[8*b +: 8] = byp_data_q[8*b +: 8];
                end
            end
        end
    end
`else
    assign ret_data = bus.mem_rdata;
`endif

    logic [DATA_BITS-1:0] a_rdata_q, h_rdata_q;
    logic                 a_ret, h_ret;

    assign a_ret = (owner_q == OWN_AXI);
    assign h_ret = (owner_q == OWN_HW);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            owner_q   <= OWN_NONE;
            a_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (a_ret) begin
                a_rdata_q <= ret_data;
            end
            if (h_ret) begin
                h_rdata_q <= ret_data;
            end
        end
    end

    assign bus.a_rvalid = a_ret;
    assign bus.h_rvalid = h_ret;
    assign bus.a_rdata  = a_ret ? ret_data : a_rdata_q;
    assign bus.h_rdata  = h_ret ? ret_data : h_rdata_q;

endmodule

// File: tb/tb_regs_port_arbiter.sv
// Randomised scoreboard bench for regs_port_arbiter with a queue-based reference model and a read-first memory.
module tb_regs_port_arbiter;

    localparam int LIMIT = 4;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    regs_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus ();

    regs_port_arbiter #(
        .ADDR_BITS    (16),
        .DATA_BITS    (32),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .aclk (clk),
        .arst (arst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  stb;
    } req_t;

    // Pending requests per source: 0 AXI write, 1 AXI read, 2 HW write, 3 HW read.
    req_t q_aw[$], q_ar[$], q_hw[$], q_hr[$];
    req_t cur[4];
    bit   act[4];

    logic [31:0] ref_mem [16];
    logic [31:0] env_mem [16];
    logic [31:0] mem_rdata_q;
    logic [31:0] a_exp[$], h_exp[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int a_wait_w = 0;
    int a_wait_r = 0;
    int a_racc_cyc = -1;
    int a_wacc_cyc = -1;
    bit rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] stb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (stb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic req_t mk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r.addr = a;
        r.data = d;
        r.stb  = s;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk({10'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
    endfunction

    // Environment memory: write port plus registered read-first read port.
    always @(posedge clk) begin
        if (bus.mem_ren) mem_rdata_q <= env_mem[bus.mem_raddr[5:2]];
        if (bus.mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wstb[b]) env_mem[bus.mem_waddr[5:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
        end
    end
    assign bus.mem_rdata = mem_rdata_q;

    task automatic drive();
        bus.a_wen   = act[0];
        bus.a_waddr = cur[0].addr;
        bus.a_wdata = cur[0].data;
        bus.a_wstb  = cur[0].stb;
        bus.a_ren   = act[1];
        bus.a_raddr = cur[1].addr;
        bus.h_wen   = act[2];
        bus.h_waddr = cur[2].addr;
        bus.h_wdata = cur[2].data;
        bus.h_wstb  = cur[2].stb;
        bus.h_ren   = act[3];
        bus.h_raddr = cur[3].addr;
    endtask

    task automatic step();
        bit gaw, ghw, gar, ghr;
        req_t r;
        logic [31:0] rd;
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            if (q_aw.size() == 0 && $urandom_range(0, 1) == 0) q_aw.push_back(rnd_req());
            if (q_ar.size() == 0 && $urandom_range(0, 1) == 0) q_ar.push_back(rnd_req());
            if (q_hw.size() == 0 && $urandom_range(0, 3) != 0) q_hw.push_back(rnd_req());
            if (q_hr.size() == 0 && $urandom_range(0, 3) != 0) q_hr.push_back(rnd_req());
        end
        if (!act[0] && q_aw.size() != 0) begin cur[0] = q_aw.pop_front(); act[0] = 1'b1; end
        if (!act[1] && q_ar.size() != 0) begin cur[1] = q_ar.pop_front(); act[1] = 1'b1; end
        if (!act[2] && q_hw.size() != 0) begin cur[2] = q_hw.pop_front(); act[2] = 1'b1; end
        if (!act[3] && q_hr.size() != 0) begin cur[3] = q_hr.pop_front(); act[3] = 1'b1; end
        drive();
        @(negedge clk);
        // HW first unless AXI has already lost LIMIT cycles running.
        gaw = act[0] && (!act[2] || a_wait_w == LIMIT);
        ghw = act[2] && !gaw;
        gar = act[1] && (!act[3] || a_wait_r == LIMIT);
        ghr = act[3] && !gar;
        chk("a_wready", 32'(bus.a_wready), 32'(gaw));
        chk("h_wready", 32'(bus.h_wready), 32'(ghw));
        chk("a_rready", 32'(bus.a_rready), 32'(gar));
        chk("h_rready", 32'(bus.h_rready), 32'(ghr));
        if (gar || ghr) begin
            r  = gar ? cur[1] : cur[3];
            rd = ref_mem[r.addr[5:2]];
`ifdef REGS_ARB_BYPASS_EN
            if (gaw && cur[0].addr == r.addr) rd = merge(rd, cur[0].data, cur[0].stb);
            if (ghw && cur[2].addr == r.addr) rd = merge(rd, cur[2].data, cur[2].stb);
`endif
            if (gar) begin
                a_exp.push_back(rd);
                a_racc_cyc = cyc;
            end else begin
                h_exp.push_back(rd);
            end
        end
        if (gaw) begin
            ref_mem[cur[0].addr[5:2]] = merge(ref_mem[cur[0].addr[5:2]], cur[0].data, cur[0].stb);
            a_wacc_cyc = cyc;
        end
        if (ghw) ref_mem[cur[2].addr[5:2]] = merge(ref_mem[cur[2].addr[5:2]], cur[2].data, cur[2].stb);
        a_wait_w = (act[0] && !gaw) ? a_wait_w + 1 : 0;
        a_wait_r = (act[1] && !gar) ? a_wait_r + 1 : 0;
        if (gaw) act[0] = 1'b0;
        if (gar) act[1] = 1'b0;
        if (ghw) act[2] = 1'b0;
        if (ghr) act[3] = 1'b0;
        cyc++;
    endtask

    task automatic flush_stim();
        q_aw.delete(); q_ar.delete(); q_hw.delete(); q_hr.delete();
        for (int i = 0; i < 4; i++) act[i] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_aw.size() + q_ar.size() + q_hw.size() + q_hr.size()) != 0 ||
               act[0] || act[1] || act[2] || act[3]) begin
            if (n == 300) begin
                n_vec++;
                n_err++;
                $display("FAIL %s: requests still pending after %0d cycles", name, n);
                flush_stim();
                break;
            end
            step();
            n++;
        end
        repeat (3) step();
    endtask

    // Monitor: pops the scoreboard whenever a side presents read data.
    initial begin
        logic [31:0] last_a, last_h;
        last_a = '0;
        last_h = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                chk("a_rvalid in reset", 32'(bus.a_rvalid), 32'd0);
                chk("h_rvalid in reset", 32'(bus.h_rvalid), 32'd0);
                chk("a_rdata in reset", bus.a_rdata, 32'd0);
                chk("h_rdata in reset", bus.h_rdata, 32'd0);
                last_a = '0;
                last_h = '0;
            end else begin
                if (bus.a_rvalid) begin
                    if (a_exp.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL a_rvalid: return %h with no outstanding AXI read (cycle %0d)", bus.a_rdata, cyc);
                    end else begin
                        chk("a_rdata", bus.a_rdata, a_exp.pop_front());
                    end
                    last_a = bus.a_rdata;
                end else begin
                    chk("a_rdata hold", bus.a_rdata, last_a);
                end
                if (bus.h_rvalid) begin
                    if (h_exp.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL h_rvalid: return %h with no outstanding HW read (cycle %0d)", bus.h_rdata, cyc);
                    end else begin
                        chk("h_rdata", bus.h_rdata, h_exp.pop_front());
                    end
                    last_h = bus.h_rdata;
                end else begin
                    chk("h_rdata hold", bus.h_rdata, last_h);
                end
            end
        end
    end

    initial begin
        int start;
        logic [31:0] exp4;
        for (int i = 0; i < 4; i++) begin
            act[i] = 1'b0;
            cur[i] = '0;
        end
        drive();
        #1 arst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("idle mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("idle a_wready", 32'(bus.a_wready), 32'd0);
        chk("idle h_rready", 32'(bus.h_rready), 32'd0);
        @(posedge clk);
        #1 arst = 1'b0;

        for (int i = 0; i < 16; i++) q_aw.push_back(mk(16'(i * 4), 32'h5A000000 + 32'(i * 32'h00010101), 4'hF));
        drain("init");

        // Plain AXI write then read back.
        q_aw.push_back(mk(16'h0010, 32'hDEADBEEF, 4'hF));
        drain("t1 write");
        q_ar.push_back(mk(16'h0010, 32'h0, 4'h0));
        drain("t1 read");
        chk("t1 a_rdata", bus.a_rdata, 32'hDEADBEEF);

        // HW holds reads for 10 cycles, AXI must get the 5th.
        q_ar.push_back(mk(16'h0010, 32'h0, 4'h0));
        repeat (9) q_hr.push_back(rnd_req());
        start = cyc;
        drain("t2");
        chk("t2 axi read grant cycle", 32'(a_racc_cyc - start + 1), 32'd5);

        // Concurrent reads to different addresses must not swap.
        q_aw.push_back(mk(16'h0020, 32'h20202020, 4'hF));
        q_aw.push_back(mk(16'h0024, 32'h24242424, 4'hF));
        drain("t3 setup");
        q_ar.push_back(mk(16'h0020, 32'h0, 4'h0));
        q_hr.push_back(mk(16'h0024, 32'h0, 4'h0));
        drain("t3");
        chk("t3 a_rdata", bus.a_rdata, 32'h20202020);
        chk("t3 h_rdata", bus.h_rdata, 32'h24242424);

        // Same-cycle write and read to one address.
        q_aw.push_back(mk(16'h0030, 32'hAABBCCDD, 4'hF));
        drain("t4 setup");
        q_aw.push_back(mk(16'h0030, 32'h11223344, 4'h3));
        q_ar.push_back(mk(16'h0030, 32'h0, 4'h0));
        drain("t4");
`ifdef REGS_ARB_BYPASS_EN
        exp4 = 32'hAABB3344;
`else
        exp4 = 32'hAABBCCDD;
`endif
        chk("t4 a_rdata", bus.a_rdata, exp4);

        // Reset right after an AXI read grant, with the write starve counter non-zero.
        repeat (3) q_hw.push_back(rnd_req());
        q_aw.push_back(mk(16'h0034, 32'hCAFEF00D, 4'hF));
        q_ar.push_back(mk(16'h0010, 32'h0, 4'h0));
        step();
        @(posedge clk);
        #1 arst = 1'b1;
        flush_stim();
        drive();
        a_exp.delete();
        h_exp.delete();
        a_wait_w = 0;
        a_wait_r = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk);
        chk("t5 a_rvalid after release", 32'(bus.a_rvalid), 32'd0);
        q_aw.push_back(mk(16'h0034, 32'hCAFEF00D, 4'hF));
        repeat (9) q_hw.push_back(rnd_req());
        start = cyc;
        drain("t5 write contention");
        chk("t5 axi write grant cycle", 32'(a_wacc_cyc - start + 1), 32'd5);

        // Random concurrent traffic.
        rnd_mode = 1'b1;
        repeat (10000) step();
        rnd_mode = 1'b0;
        drain("random");

        chk("outstanding AXI reads", 32'(a_exp.size()), 32'd0);
        chk("outstanding HW reads", 32'(h_exp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
